// File: rtl/exu_div_pkg.sv
// Shared definitions for the EXU iterative divider: op encoding, FSM states
// and the op decoder used when a request is accepted.
package exu_div_pkg;

  localparam int REG_DATA_WIDTH = 32;

  // Bit positions inside the one-hot op_i vector {remu,rem,divu,div}.
  localparam int DIV_OP_DIV  = 0;
  localparam int DIV_OP_DIVU = 1;
  localparam int DIV_OP_REM  = 2;
  localparam int DIV_OP_REMU = 3;
  localparam int DIV_OP_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } div_state_e;

  typedef struct packed {
    logic is_signed;
    logic is_rem;
  } div_op_t;

  // Multi-hot requests resolve with priority div > divu > rem > remu.
  function automatic div_op_t decode_op(input logic [DIV_OP_W-1:0] op);
    div_op_t d;
    d.is_signed = 1'b0;
    d.is_rem    = 1'b0;
    if (op[DIV_OP_DIV]) begin
      d.is_signed = 1'b1;
    end else if (op[DIV_OP_DIVU]) begin
      d.is_signed = 1'b0;
    end else if (op[DIV_OP_REM]) begin
      d.is_signed = 1'b1;
      d.is_rem    = 1'b1;
    end else if (op[DIV_OP_REMU]) begin
      d.is_rem    = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/exu_div_gnrl.sv
// Generic flop cells used for every register in the divider.
// gnrl_dfflr: load-enabled flop; gnrl_dffr: free-running flop.
// Both clear asynchronously on rst_n low.
module gnrl_dfflr #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  logic [DW-1:0] qout_q;

  // Capture dnxt only when lden is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qout_q <= '0;
    end else if (lden) begin
      qout_q <= dnxt;
    end
  end

  assign qout = qout_q;

endmodule

module gnrl_dffr #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  logic [DW-1:0] qout_q;

  // Capture dnxt every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qout_q <= '0;
    end else begin
      qout_q <= dnxt;
    end
  end

  assign qout = qout_q;

endmodule

// File: rtl/exu_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor and keep the difference
// when it does not go negative. The quotient bit is shifted into the
// dividend register as its bits are consumed.
module exu_div_step #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] rem_i,
  input  logic [DW-1:0] dvd_i,
  input  logic [DW-1:0] dvsr_i,
  output logic [DW-1:0] rem_nxt_o,
  output logic [DW-1:0] dvd_nxt_o,
  output logic          qbit_o
);

  logic [DW:0]   trial;
  logic [DW+1:0] diff;
  logic          unused_bits;

  // The extra top bit acts as the borrow, so a divisor magnitude of
  // 0x80000000 (or any full-width value) never overflows the compare.
  assign trial     = {rem_i, dvd_i[DW-1]};
  assign diff      = {1'b0, trial} - {2'b00, dvsr_i};
  assign qbit_o    = ~diff[DW+1];
  // The partial remainder stays below the divisor, so bit DW of either
  // candidate is zero whenever it is selected.
  assign rem_nxt_o = qbit_o ? diff[DW-1:0] : trial[DW-1:0];
  assign dvd_nxt_o = {dvd_i[DW-2:0], qbit_o};

  assign unused_bits = diff[DW] ^ trial[DW];

endmodule

// File: rtl/exu_divider.sv
// EXU iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; completion is a one-cycle valid_o pulse and
// result_o holds until the next completed request.
module exu_divider
  import exu_div_pkg::*;
#(
  parameter int DW = REG_DATA_WIDTH,
  parameter int CW = $clog2(DW)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [DW-1:0]       dividend_i,
  input  logic [DW-1:0]       divisor_i,
  input  logic [DIV_OP_W-1:0] op_i,
  output logic [DW-1:0]       result_o,
  output logic                busy_o,
  output logic                valid_o
);

  localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

  // {is_signed, is_rem, quotient negative, remainder negative}
  localparam int FW = 4;

  div_state_e    state_q, state_d;
  logic [1:0]    state_raw;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cnt_en;
  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic          dp_en;
  logic [DW-1:0] dvsr_q, dvsr_d;
  logic [FW-1:0] flags_q, flags_d;
  logic          ld_en;
  logic [DW-1:0] res_q, res_d;
  logic          res_en;

  // Request-side decode, evaluated in IDLE only.
  div_op_t       dec;
  logic          accept;
  logic          dvd_neg, dvsr_neg;
  logic [DW-1:0] abs_dvd, abs_dvsr;
  logic          dvsr_zero, ovf, special;
  logic [DW-1:0] spec_res;

  // Iteration and sign-fixup datapath.
  logic [DW-1:0] step_rem, step_dvd;
  logic          step_qbit_unused;
  logic          f_signed, f_isrem, f_qneg, f_rneg;
  logic [DW-1:0] q_fin, r_fin;

  assign dec       = decode_op(op_i);
  assign accept    = start_i && (state_q == IDLE) && (op_i != '0);
  assign dvd_neg   = dec.is_signed & dividend_i[DW-1];
  assign dvsr_neg  = dec.is_signed & divisor_i[DW-1];
  assign abs_dvd   = dvd_neg ? (-dividend_i) : dividend_i;
  assign abs_dvsr  = dvsr_neg ? (-divisor_i) : divisor_i;
  assign dvsr_zero = (divisor_i == '0);
  assign ovf       = dec.is_signed && (dividend_i == MIN_NEG) && (&divisor_i);
  assign special   = dvsr_zero | ovf;

  // RISC-V defined results: x/0 -> all ones (rem -> x); MIN/-1 -> MIN (rem -> 0).
  assign spec_res  = dvsr_zero ? (dec.is_rem ? dividend_i : '1)
                               : (dec.is_rem ? '0 : dividend_i);

  assign {f_signed, f_isrem, f_qneg, f_rneg} = flags_q;
  assign q_fin = (f_signed && f_qneg) ? (-dvd_q) : dvd_q;
  assign r_fin = (f_signed && f_rneg) ? (-rem_q) : rem_q;

  exu_div_step #(.DW(DW)) u_step (
    .rem_i     (rem_q),
    .dvd_i     (dvd_q),
    .dvsr_i    (dvsr_q),
    .rem_nxt_o (step_rem),
    .dvd_nxt_o (step_dvd),
    .qbit_o    (step_qbit_unused)
  );

  // Next-state and register-load control for IDLE -> CALC -> SIGN -> DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_en  = 1'b0;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dp_en   = 1'b0;
    dvsr_d  = dvsr_q;
    flags_d = flags_q;
    ld_en   = 1'b0;
    res_d   = res_q;
    res_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ld_en   = 1'b1;
          dvsr_d  = abs_dvsr;
          flags_d = {dec.is_signed, dec.is_rem, dvd_neg ^ dvsr_neg, dvd_neg};
          dp_en   = 1'b1;
          rem_d   = '0;
          dvd_d   = abs_dvd;
          cnt_en  = 1'b1;
          cnt_d   = CW'(DW - 1);
          if (special) begin
            res_en  = 1'b1;
            res_d   = spec_res;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        dp_en = 1'b1;
        rem_d = step_rem;
        dvd_d = step_dvd;
        if (cnt_q == '0) begin
          state_d = SIGN;
        end else begin
          cnt_en = 1'b1;
          cnt_d  = cnt_q - CW'(1);
        end
      end
      SIGN: begin
        res_en  = 1'b1;
        res_d   = f_isrem ? r_fin : q_fin;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  gnrl_dffr  #(.DW(2))  u_state (.clk(clk), .rst_n(rst_n), .dnxt(state_d), .qout(state_raw));
  gnrl_dfflr #(.DW(CW)) u_cnt   (.clk(clk), .rst_n(rst_n), .lden(cnt_en), .dnxt(cnt_d),   .qout(cnt_q));
  gnrl_dfflr #(.DW(DW)) u_rem   (.clk(clk), .rst_n(rst_n), .lden(dp_en),  .dnxt(rem_d),   .qout(rem_q));
  gnrl_dfflr #(.DW(DW)) u_dvd   (.clk(clk), .rst_n(rst_n), .lden(dp_en),  .dnxt(dvd_d),   .qout(dvd_q));
  gnrl_dfflr #(.DW(DW)) u_dvsr  (.clk(clk), .rst_n(rst_n), .lden(ld_en),  .dnxt(dvsr_d),  .qout(dvsr_q));
  gnrl_dfflr #(.DW(FW)) u_flags (.clk(clk), .rst_n(rst_n), .lden(ld_en),  .dnxt(flags_d), .qout(flags_q));
  gnrl_dfflr #(.DW(DW)) u_res   (.clk(clk), .rst_n(rst_n), .lden(res_en), .dnxt(res_d),   .qout(res_q));

  assign state_q  = div_state_e'(state_raw);
  assign result_o = res_q;
  assign busy_o   = (state_q != IDLE);
  assign valid_o  = (state_q == DONE);

endmodule
